maxil_read_top: RTL
===================

// Module: maxil_read_top
// PURPOSE
// - AXI4-Lite master read engine; the upstream stage that drives the saxil_read_top AR channel and consumes its R channel.
// - Takes one read command at a time from a local valid/ready command port.
// - Issues AR, accepts R, and returns data plus response on a local valid/ready response port.
// - Single outstanding transaction; no ID, no bursts.
// PARAMETERS
// - ADDR_WIDTH  32  width of cmd_addr / araddr
// - DATA_WIDTH  32  width of rdata / rsp_data; 32 or 64 only
// PORTS
// - maxil_read_top_clk  in  1  single clock; all logic on rising edge
// - maxil_read_top_rst  in  1  synchronous, active-high reset
// - maxil_read_cmd_valid  in  1  command request
// - maxil_read_cmd_ready  out  1  command accepted when valid&ready
// - maxil_read_cmd_addr  in  ADDR_WIDTH  read byte address
// - maxil_read_cmd_prot  in  3  AXI protection bits, passed to arprot
// - maxil_read_arvalid  out  1  AXI AR valid
// - maxil_read_arready  in  1  AXI AR ready
// - maxil_read_araddr  out  ADDR_WIDTH  AXI AR address
// - maxil_read_arprot  out  3  AXI AR prot
// - maxil_read_rvalid  in  1  AXI R valid
// - maxil_read_rready  out  1  AXI R ready
// - maxil_read_rdata  in  DATA_WIDTH  AXI R data
// - maxil_read_rresp  in  2  AXI R response
// - maxil_read_rsp_valid  out  1  result available
// - maxil_read_rsp_ready  in  1  result consumed when valid&ready
// - maxil_read_rsp_data  out  DATA_WIDTH  returned data
// - maxil_read_rsp_resp  out  2  returned response code
// BEHAVIOUR
// - FSM states: IDLE -> ADDR -> DATA -> RESP -> IDLE. Local-error path: IDLE -> RESP.
// - Reset (synchronous, high):
//   - state=IDLE; arvalid=0, rready=0, rsp_valid=0.
//   - araddr=0, arprot=0, rsp_data=0, rsp_resp=0.
//   - Reset mid-transaction abandons it immediately; no AR/R handshake is completed afterwards.
// - cmd_ready=1 only in IDLE (registered state decode). It is 0 during reset.
// - IDLE, cmd handshake, aligned address:
//   - latch addr/prot into araddr/arprot; go to ADDR.
//   - arvalid=1 on the next cycle.
// - Misaligned address (addr[log2(DATA_WIDTH/8)-1:0] != 0):
//   - no AR issued; go to RESP with rsp_data=0, rsp_resp=2'b10 (SLVERR).
// - ADDR:
//   - arvalid held 1; araddr/arprot held stable until arready.
//   - On arvalid&arready: arvalid=0 next cycle, rready=1 next cycle; go to DATA.
// - DATA:
//   - rready held 1; rvalid while in ADDR is ignored (rready=0 there).
//   - On rvalid&rready: capture rdata/rresp; rready=0, rsp_valid=1 next cycle; go to RESP.
// - RESP:
//   - rsp_valid held 1; rsp_data/rsp_resp stable.
//   - On rsp_ready: rsp_valid=0, return to IDLE. A new command may be accepted the following cycle.
// - Latency (zero-wait slave and sink): cmd handshake edge N; arvalid at N+1; rready at N+2; rsp_valid at N+3 -> 4-cycle throughput.
// - arready already high: handshake occurs in the first ADDR cycle.
// - rresp is passed through unchanged (OKAY/EXOKAY/SLVERR/DECERR).
// - No combinational path from any input to any output; all outputs registered.
// CONFIGURATION
// - Macro MAXIL_READ_ERR_CNT_EN. Defined:
//   - adds output maxil_read_err_cnt [15:0], reset 0.
//   - +1 on each rsp handshake with rsp_resp[1]=1, including local misalignment errors.
//   - saturates at 16'hFFFF.
// - Not defined: port and counter absent; behaviour otherwise identical.
// TESTING
// - Reset: rst high 2 cycles, mid-ADDR -> arvalid=0, cmd_ready=1 on the first cycle after rst falls.
// - cmd addr=32'hFFFF_FFFC, prot=0; arready=1; rvalid=1, rdata=32'hDEAD_BEEF, rresp=0 -> araddr=FFFF_FFFC; rsp_data=DEAD_BEEF, rsp_resp=0 at N+3.
// - cmd addr=32'hF0F0_F0F0; arready held low 5 cycles -> arvalid=1 and araddr stable for all 5; completes after arready.
// - cmd addr=32'h0000_0003 -> no arvalid ever; rsp_resp=2'b10, rsp_data=0; err_cnt=1 when MAXIL_READ_ERR_CNT_EN.
// - rvalid=1 with rresp=2'b11 and rsp_ready low 4 cycles -> rsp_valid held, rsp_resp=3, cmd_ready=0 until rsp handshake.
// - Back-to-back: 2 cmds at FFFF_FFFF-aligned 0xFFFF_FFFC then 0xF0F0_F0F0 -> second arvalid no earlier than 1 cycle after first rsp handshake.

Source files
------------

// File: rtl/maxil_read_top_if.sv
// Command/response ports and AXI4-Lite AR/R channels of the read engine; master = engine side.
// MAXIL_READ_ERR_CNT_EN adds the saturating error counter output.
interface maxil_read_top_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  maxil_read_cmd_valid;
    logic                  maxil_read_cmd_ready;
    logic [ADDR_WIDTH-1:0] maxil_read_cmd_addr;
    logic [2:0]            maxil_read_cmd_prot;

    logic                  maxil_read_arvalid;
    logic                  maxil_read_arready;
    logic [ADDR_WIDTH-1:0] maxil_read_araddr;
    logic [2:0]            maxil_read_arprot;

    logic                  maxil_read_rvalid;
    logic                  maxil_read_rready;
    logic [DATA_WIDTH-1:0] maxil_read_rdata;
    logic [1:0]            maxil_read_rresp;

    logic                  maxil_read_rsp_valid;
    logic                  maxil_read_rsp_ready;
    logic [DATA_WIDTH-1:0] maxil_read_rsp_data;
    logic [1:0]            maxil_read_rsp_resp;
`ifdef MAXIL_READ_ERR_CNT_EN
    logic [15:0]           maxil_read_err_cnt;
`endif

    modport master (
        input  maxil_read_cmd_valid,
        input  maxil_read_cmd_addr,
        input  maxil_read_cmd_prot,
        output maxil_read_cmd_ready,
        output maxil_read_arvalid,
        input  maxil_read_arready,
        output maxil_read_araddr,
        output maxil_read_arprot,
        input  maxil_read_rvalid,
        output maxil_read_rready,
        input  maxil_read_rdata,
        input  maxil_read_rresp,
        output maxil_read_rsp_valid,
        input  maxil_read_rsp_ready,
        output maxil_read_rsp_data,
        output maxil_read_rsp_resp
`ifdef MAXIL_READ_ERR_CNT_EN
        , output maxil_read_err_cnt
`endif
    );

    modport slave (
        output maxil_read_cmd_valid,
        output maxil_read_cmd_addr,
        output maxil_read_cmd_prot,
        input  maxil_read_cmd_ready,
        input  maxil_read_arvalid,
        output maxil_read_arready,
        input  maxil_read_araddr,
        input  maxil_read_arprot,
        output maxil_read_rvalid,
        input  maxil_read_rready,
        output maxil_read_rdata,
        output maxil_read_rresp,
        input  maxil_read_rsp_valid,
        output maxil_read_rsp_ready,
        input  maxil_read_rsp_data,
        input  maxil_read_rsp_resp
`ifdef MAXIL_READ_ERR_CNT_EN
        , input maxil_read_err_cnt
`endif
    );
endinterface

// File: rtl/maxil_read_top.sv
// AXI4-Lite single-outstanding read master: cmd -> AR -> R -> rsp, 4-cycle round trip with zero-wait peers.
// All outputs registered; stalls on arready/rvalid/rsp_ready. MAXIL_READ_ERR_CNT_EN adds err_cnt.
module maxil_read_top #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 maxil_read_top_clk,
    input  logic                 maxil_read_top_rst,
    maxil_read_top_if.master     bus
);
    localparam int LSB_W = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;

    logic                  cmd_ready_q,  cmd_ready_d;
    logic                  arvalid_q,    arvalid_d;
    logic                  rready_q,     rready_d;
    logic                  rsp_valid_q,  rsp_valid_d;
    logic [ADDR_WIDTH-1:0] araddr_q,     araddr_d;
    logic [2:0]            arprot_q,     arprot_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,   rsp_data_d;
    logic [1:0]            rsp_resp_q,   rsp_resp_d;

    logic                  cmd_fire;
    logic                  ar_fire;
    logic                  r_fire;
    logic                  rsp_fire;
    logic                  misaligned;

    assign cmd_fire   = bus.maxil_read_cmd_valid & cmd_ready_q;
    assign ar_fire    = arvalid_q & bus.maxil_read_arready;
    assign r_fire     = rready_q & bus.maxil_read_rvalid;
    assign rsp_fire   = rsp_valid_q & bus.maxil_read_rsp_ready;
    assign misaligned = |bus.maxil_read_cmd_addr[LSB_W-1:0];

    // State and every output are flopped here; reset abandons any transaction in flight.
    always_ff @(posedge maxil_read_top_clk) begin
        if (maxil_read_top_rst) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            araddr_q    <= '0;
            arprot_q    <= '0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state       <= next_state;
            cmd_ready_q <= cmd_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            araddr_q    <= araddr_d;
            arprot_q    <= arprot_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (cmd_fire) next_state = misaligned ? RESP : ADDR;
            ADDR: if (ar_fire)  next_state = DATA;
            DATA: if (r_fire)   next_state = RESP;
            RESP: if (rsp_fire) next_state = IDLE;
            default:            next_state = IDLE;
        endcase
    end

    // Handshake flags are a one-cycle-ahead decode of next_state so they appear registered.
    always_comb begin
        cmd_ready_d = (next_state == IDLE);
        arvalid_d   = (next_state == ADDR);
        rready_d    = (next_state == DATA);
        rsp_valid_d = (next_state == RESP);
        araddr_d    = araddr_q;
        arprot_d    = arprot_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        if (state == IDLE && cmd_fire) begin
            if (misaligned) begin
                rsp_data_d = '0;
                rsp_resp_d = 2'b10;
            end else begin
                araddr_d = bus.maxil_read_cmd_addr;
                arprot_d = bus.maxil_read_cmd_prot;
            end
        end
        if (state == DATA && r_fire) begin
            rsp_data_d = bus.maxil_read_rdata;
            rsp_resp_d = bus.maxil_read_rresp;
        end
    end

    assign bus.maxil_read_cmd_ready = cmd_ready_q;
    assign bus.maxil_read_arvalid   = arvalid_q;
    assign bus.maxil_read_araddr    = araddr_q;
    assign bus.maxil_read_arprot    = arprot_q;
    assign bus.maxil_read_rready    = rready_q;
    assign bus.maxil_read_rsp_valid = rsp_valid_q;
    assign bus.maxil_read_rsp_data  = rsp_data_q;
    assign bus.maxil_read_rsp_resp  = rsp_resp_q;

`ifdef MAXIL_READ_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // SLVERR/DECERR (bit 1 set) counted at delivery, local misalignment included.
    always_ff @(posedge maxil_read_top_clk) begin
        if (maxil_read_top_rst) begin
            err_cnt_q <= '0;
        end else if (rsp_fire && rsp_resp_q[1] && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign bus.maxil_read_err_cnt = err_cnt_q;
`endif
endmodule
